// File: rtl/fetch_decode_fifo.sv
// Multi-lane circular FIFO between fetch and decode: up to FETCH_WIDTH pushes
// and DECODE_WIDTH pops per cycle, oldest entries presented on the low lanes.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

package fetch_decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] value;
    logic [4:0]  exception;
    logic [1:0]  prediction;
    logic [3:0]  checkpoint;
  } fetch_decode_pack_t;
endpackage

module fetch_decode_fifo
  import fetch_decode_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = `FETCH_WIDTH,
  parameter int DECODE_WIDTH = `DECODE_WIDTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  fetch_decode_pack_t       data_in_i [0:FETCH_WIDTH-1],
  input  logic [FETCH_WIDTH-1:0]   data_in_valid_i,
  input  logic                     push_i,
  output logic [FETCH_WIDTH-1:0]   data_in_enable_o,
  output fetch_decode_pack_t       data_out_o [0:DECODE_WIDTH-1],
  output logic [DECODE_WIDTH-1:0]  data_out_valid_o,
  input  logic [DECODE_WIDTH-1:0]  data_pop_valid_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [CW-1:0]            count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  fetch_decode_pack_t mem [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic [CW-1:0] accepted, removed;
  logic [FETCH_WIDTH-1:0] laneWrite;

  // Enable and valid masks come from registered occupancy only, so a pop
  // never frees a push slot in the same cycle and a push is never bypassed.
  always_comb begin
    free = CW'(DEPTH) - count_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      data_in_enable_o[i] = (free > CW'(i));
    end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      data_out_valid_o[i] = (count_q > CW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      data_out_o[i] = data_out_valid_o[i] ? mem[rptr_q + PW'(i)] : '0;
    end
  end

  always_comb begin
    accepted = '0;
    removed  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      laneWrite[i] = push_i && data_in_valid_i[i] && data_in_enable_o[i];
      if (laneWrite[i]) accepted = accepted + CW'(1);
    end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (pop_i && data_pop_valid_i[i] && data_out_valid_o[i]) removed = removed + CW'(1);
    end
  end

  always_comb begin
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      rptr_d  = rptr_q + PW'(removed);
      wptr_d  = wptr_q + PW'(accepted);
      count_d = count_q + accepted - removed;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately unreset; output masking keeps data_out clean.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (laneWrite[i] && !flush_i) mem[wptr_q + PW'(i)] <= data_in_i[i];
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

`ifndef SYNTHESIS
  logic [FETCH_WIDTH-1:0]  pushProbe;
  logic [DECODE_WIDTH-1:0] popProbe;
  assign pushProbe = data_in_valid_i + FETCH_WIDTH'(1);
  assign popProbe  = data_pop_valid_i + DECODE_WIDTH'(1);

  always @(posedge clk_i) begin
    if (rst_ni && push_i) assert ((data_in_valid_i & pushProbe) == '0);
    if (rst_ni && pop_i) assert ((data_pop_valid_i & popProbe) == '0);
  end
`endif

endmodule

// File: doc/fetch_decode_fifo.md
FETCH_DECODE_FIFO -- requirements
Module: fetch_decode_fifo

Interface
REQ-001 Parameter DEPTH, 16, number of entries; power of two, at least max(FETCH_WIDTH, DECODE_WIDTH).
REQ-002 Parameter FETCH_WIDTH, `FETCH_WIDTH, push lanes per cycle.
REQ-003 Parameter DECODE_WIDTH, `DECODE_WIDTH, pop lanes per cycle.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 data_in[0:FETCH_WIDTH-1]  in  fetch_decode_pack_t  entries from fetch.
REQ-007 data_in_valid  in  FETCH_WIDTH  per-lane push request; contiguous prefix mask from bit 0.
REQ-008 push  in  1  push strobe; qualifies data_in_valid.
REQ-009 data_in_enable  out  FETCH_WIDTH  bit i=1 iff free slots > i.
REQ-010 data_out[0:DECODE_WIDTH-1]  out  fetch_decode_pack_t  oldest entries, lane 0 oldest.
REQ-011 data_out_valid  out  DECODE_WIDTH  bit i=1 iff occupancy > i.
REQ-012 data_pop_valid  in  DECODE_WIDTH  per-lane pop request from decode; contiguous prefix mask.
REQ-013 pop  in  1  pop strobe; qualifies data_pop_valid.
REQ-014 flush  in  1  synchronous discard of all contents.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-017 Storage: DEPTH-entry circular buffer; rptr, wptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count kept separately, 0..DEPTH.
REQ-018 Lanes accepted = popcount(data_in_valid & data_in_enable) when push=1, else 0; lane i written to (wptr+i) mod DEPTH.
REQ-019 Lanes removed = popcount(data_pop_valid & data_out_valid) when pop=1, else 0.
REQ-020 Next state: wptr += accepted, rptr += removed, count += accepted - removed, all in the same edge.
REQ-021 data_in_enable derived from registered count only; pops in the same cycle never free push slots (no pass-through).
REQ-022 data_out[i] = entry at (rptr+i) mod DEPTH when data_out_valid[i]=1, else all-zero; no bypass: pushed entries appear earliest the cycle after the push edge.
REQ-023 Request bits beyond enable/valid masks are silently dropped; never cause overflow, underflow or pointer corruption.
REQ-024 Non-prefix data_in_valid or data_pop_valid is illegal; simulation assertion fires; RTL behaviour undefined.
REQ-025 flush=1: next edge rptr=wptr=0, count=0; overrides push and pop in the same cycle; entries written that cycle are discarded.
REQ-026 Full (count==DEPTH): data_in_enable=0; a simultaneous pop still proceeds.
REQ-027 Empty: data_out_valid=0; a simultaneous push still proceeds.
REQ-028 Wrap: push or pop spanning index DEPTH-1 to 0 in one cycle handled lane-by-lane, order preserved.
REQ-029 Packet fields (pc, value, exception, prediction, checkpoint) stored and returned bit-exact.

Reset
REQ-030 rst=0 asynchronously forces rptr=0, wptr=0, count=0 regardless of clk.
REQ-031 During reset: data_out_valid=0, data_out all-zero, count=0, empty=1, full=0, data_in_enable all ones.
REQ-032 Storage array not reset; masking per REQ-022 keeps outputs deterministic.
REQ-033 Reset asserted mid-operation discards all contents; first edge after release behaves as empty FIFO.

Verification (DEPTH=16, FETCH_WIDTH=DECODE_WIDTH=4)
REQ-034 Reset, push 4 lanes pc=0x80000000..0x8000000c -> next cycle count=4, data_out_valid=4'b1111, data_out[0].pc=0x80000000, data_out[3].pc=0x8000000c.
REQ-035 Fill to count=14, push valid=4'b1111 -> data_in_enable=4'b0011, two accepted, count=16, full=1, data_in_enable=0.
REQ-036 count=16, push 4 + pop 4 same cycle -> 0 accepted (no pass-through), 4 removed, count=12, data_in_enable=4'b1111.
REQ-037 rptr=wptr=14, count=0: push 4 then pop 4 -> entries land at 14,15,0,1; popped in push order; rptr=wptr=2, count=0.
REQ-038 count=9, flush=1 with push 4 and pop 2 -> count=0, empty=1, data_out_valid=0; next push of 1 lane reads back at data_out[0].
REQ-039 count=6, drive rst=0 between edges -> count=0, data_out_valid=0 immediately, before next clk edge.
